// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   - RX FSM state encodings and the enum built from them
//   - parity-type constants (shared with the TX path)
//   - the legal oversampling ratios
package uart_pkg;

  localparam logic [2:0] RX_IDLE_ENC   = 3'd0;
  localparam logic [2:0] RX_START_ENC  = 3'd1;
  localparam logic [2:0] RX_DATA_ENC   = 3'd2;
  localparam logic [2:0] RX_PARITY_ENC = 3'd3;
  localparam logic [2:0] RX_STOP_ENC   = 3'd4;
  localparam logic [2:0] RX_DONE_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = RX_IDLE_ENC,
    ST_START  = RX_START_ENC,
    ST_DATA   = RX_DATA_ENC,
    ST_PARITY = RX_PARITY_ENC,
    ST_STOP   = RX_STOP_ENC,
    ST_DONE   = RX_DONE_ENC
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: three-point mid-bit capture with 2-of-3 majority vote.
//   CLK         oversampling clock
//   RST         synchronous active-high reset
//   rx_s        synchronised serial line
//   edge_cnt    position inside the current bit (0..P-1)
//   half_p      P/2 for the latched prescale
//   sampled_bit majority of the samples at P/2-1, P/2, P/2+1;
//               stable from edge_cnt = P/2+2 to the end of the bit
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] half_p,
  output logic                  sampled_bit
);

  logic [2:0] taps;

  // Tap gi captures at edge_cnt = half_p + gi - 1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    logic [PRESCALE_W-1:0] tap_pos;
    logic                  tap_q;

    assign tap_pos = half_p + PRESCALE_W'(gi) - PRESCALE_W'(1);

    always_ff @(posedge CLK) begin
      if (RST) begin
        tap_q <= 1'b1;
      end else if (edge_cnt == tap_pos) begin
        tap_q <= rx_s;
      end
    end

    assign taps[gi] = tap_q;
  end

  assign sampled_bit = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver on a PRESCALE x baud oversampling clock.
//   CLK, RST          clock, synchronous active-high reset
//   RX_IN             serial line (idle high, asynchronous)
//   PRESCALE          oversampling ratio (8/16/32, anything else -> 8)
//   PAR_EN, PAR_TYP   parity present / 0 even, 1 odd
//   P_DATA            last good received word
//   DATA_VALID        one-cycle pulse, P_DATA holds a new word
//   PAR_ERR, STP_ERR  one-cycle error pulses (may coincide)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  logic                  sync1_q, sync2_q, rx_s;
  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;

  logic [PRESCALE_W-1:0] prescale_legal;
  logic [PRESCALE_W-1:0] half_p;
  logic                  bit_end;
  logic                  sampled_bit;
  logic                  exp_parity;
  logic                  start_frame;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  always_comb begin
    prescale_legal = PRESCALE_W'(PRESCALE_8);
    if (PRESCALE == PRESCALE_W'(PRESCALE_16) || PRESCALE == PRESCALE_W'(PRESCALE_32)) begin
      prescale_legal = PRESCALE;
    end
  end

  assign half_p     = p_q >> 1;
  assign bit_end    = (edge_cnt_q == p_q - PRESCALE_W'(1));
  assign exp_parity = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .rx_s       (rx_s),
    .edge_cnt   (edge_cnt_q),
    .half_p     (half_p),
    .sampled_bit(sampled_bit)
  );

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    p_d         = p_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_bad_d   = par_bad_q;
    stp_bad_d   = stp_bad_q;
    start_frame = 1'b0;

    if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
      if (bit_end) bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: start_frame = !rx_s;
      ST_START: begin
        if (bit_end) begin
          // A start bit that is high at mid-bit was a glitch.
          if (sampled_bit) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_bad_d = (sampled_bit != exp_parity);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stp_bad_d = !sampled_bit;
          // Load the word on the way into DONE so it is already on P_DATA
          // during the DATA_VALID cycle.
          if (!par_bad_q && sampled_bit) p_data_d = shift_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!rx_s) start_frame = 1'b1;
        else       state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Configuration is frozen for the whole frame from here on.
    if (start_frame) begin
      state_d    = ST_START;
      edge_cnt_d = '0;
      p_d        = prescale_legal;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      par_bad_d  = 1'b0;
      stp_bad_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      p_q        <= PRESCALE_W'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_bad_q  <= 1'b0;
      stp_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      p_q        <= p_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      stp_bad_q  <= stp_bad_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = (state_q == ST_DONE) && !par_bad_q && !stp_bad_q;
  assign PAR_ERR    = (state_q == ST_DONE) && par_bad_q;
  assign STP_ERR    = (state_q == ST_DONE) && stp_bad_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a frame-level model.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int unsigned   cyc = 0;
  int            dv_n = 0, pe_n = 0, se_n = 0, long_n = 0;
  int unsigned   dv_cyc = 0;
  logic [DW-1:0] dv_q[$];
  logic          dv_p = 1'b0, pe_p = 1'b0, se_p = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID) begin
      dv_n   <= dv_n + 1;
      dv_cyc <= cyc;
      dv_q.push_back(P_DATA);
    end
    if (PAR_ERR) pe_n <= pe_n + 1;
    if (STP_ERR) se_n <= se_n + 1;
    if ((DATA_VALID && dv_p) || (PAR_ERR && pe_p) || (STP_ERR && se_p)) long_n <= long_n + 1;
    dv_p <= DATA_VALID;
    pe_p <= PAR_ERR;
    se_p <= STP_ERR;
  end

  // ---------------- frame-level model ----------------
  bit            line_q[$];     // one entry per CLK cycle of RX_IN
  logic [DW-1:0] exp_data_q[$];
  int            exp_pe = 0, exp_se = 0;
  logic [DW-1:0] exp_pdata = '0;
  int            cur_p = 8;
  bit            cur_pen = 0, cur_ptyp = 0;
  int unsigned   drive_t0 = 0;

  task automatic begin_batch(input int p_in, input bit pen, input bit ptyp);
    cur_p    = (p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8;
    cur_pen  = pen;
    cur_ptyp = ptyp;
    PRESCALE = PW'(p_in);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
  endtask

  task automatic push_bit(input bit b);
    repeat (cur_p) line_q.push_back(b);
  endtask

  task automatic push_frame(input logic [DW-1:0] data, input bit par_bit, input bit stop_v);
    push_bit(1'b0);
    for (int i = 0; i < DW; i++) push_bit(data[i]);
    if (cur_pen) push_bit(par_bit);
    push_bit(stop_v);
  endtask

  // Appends a frame and records what the receiver must report for it.
  task automatic add_frame(input logic [DW-1:0] data, input bit flip_par, input bit stop_v);
    bit good_par, p_err, s_err;
    good_par = cur_ptyp ? ~(^data) : ^data;
    push_frame(data, good_par ^ flip_par, stop_v);
    p_err = cur_pen && flip_par;
    s_err = !stop_v;
    if (!p_err && !s_err) begin
      exp_data_q.push_back(data);
      exp_pdata = data;
    end else begin
      exp_pe += int'(p_err);
      exp_se += int'(s_err);
    end
  endtask

  // Plays line_q (optionally pulsing RST for 2 cycles at index rst_at and
  // holding the line idle from then on), then compares against the model.
  task automatic drive(input string tag, input int idle, input int rst_at);
    int b_dv, b_pe, b_se;
    b_dv = dv_n;
    b_pe = pe_n;
    b_se = se_n;
    drive_t0 = cyc;
    for (int i = 0; i < line_q.size(); i++) begin
      RST   = (rst_at >= 0 && i >= rst_at && i < rst_at + 2);
      RX_IN = (rst_at >= 0 && i >= rst_at) ? 1'b1 : line_q[i];
      @(posedge CLK); #1;
    end
    RST   = 1'b0;
    RX_IN = 1'b1;
    repeat (idle) @(posedge CLK);
    #1;
    chk({tag, "/dv_count"}, dv_n - b_dv, exp_data_q.size());
    chk({tag, "/par_err_count"}, pe_n - b_pe, exp_pe);
    chk({tag, "/stp_err_count"}, se_n - b_se, exp_se);
    for (int i = 0; i < exp_data_q.size(); i++) begin
      if (b_dv + i < dv_q.size()) chk({tag, "/data"}, dv_q[b_dv + i], exp_data_q[i]);
    end
    chk({tag, "/p_data"}, P_DATA, exp_pdata);
    $display("%s: P=%0d pen=%0d ptyp=%0d good=%0d par_err=%0d stp_err=%0d p_data=%02h",
             tag, cur_p, cur_pen, cur_ptyp, dv_n - b_dv, pe_n - b_pe, se_n - b_se, P_DATA);
    line_q.delete();
    exp_data_q.delete();
    exp_pe = 0;
    exp_se = 0;
  endtask

  initial begin
    int plist[5];
    plist = '{8, 16, 32, 12, 0};
    RST = 1'b1;
    RX_IN = 1'b1;
    PRESCALE = PW'(8);
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset/p_data", P_DATA, 0);
    chk("reset/dv", DATA_VALID, 0);
    chk("reset/par_err", PAR_ERR, 0);
    chk("reset/stp_err", STP_ERR, 0);

    // P=8, no parity, 0xA5. The first edge that samples the low start bit
    // is drive_t0+1; the pulse is 10*P+2 edges after that one.
    begin_batch(8, 0, 0);
    add_frame(8'hA5, 0, 1);
    drive("p8_a5", 8, -1);
    chk("p8_a5/latency", dv_cyc - drive_t0, 10 * 8 + 3);

    // P=16 even parity: good parity then bad parity.
    begin_batch(16, 1, 0);
    add_frame(8'h3C, 0, 1);
    drive("p16_par_ok", 8, -1);
    add_frame(8'h3C, 1, 1);
    drive("p16_par_bad", 8, -1);

    // P=32 stop bit low, then a clean frame.
    begin_batch(32, 0, 0);
    add_frame(8'h81, 0, 0);
    drive("p32_stop_bad", 8, -1);
    add_frame(8'h7E, 0, 1);
    drive("p32_7e", 8, -1);

    // 3-cycle start glitch at P=16, then 0x55.
    begin_batch(16, 0, 0);
    repeat (3) line_q.push_back(1'b0);
    drive("start_glitch", 40, -1);
    add_frame(8'h55, 0, 1);
    drive("after_glitch", 8, -1);

    // One-cycle glitch in the middle of data bit 2 (frame bit 3).
    add_frame(8'hF0, 0, 1);
    line_q[3 * 16 + 8] = ~line_q[3 * 16 + 8];
    drive("majority", 8, -1);

    // Back-to-back 0x11, 0x22, then reset in the middle of a third frame.
    begin_batch(8, 0, 0);
    add_frame(8'h11, 0, 1);
    add_frame(8'h22, 0, 1);
    push_frame(8'h33, 1'b0, 1'b1);
    exp_pdata = '0;
    drive("b2b_reset", 8, 20 * 8 + 40);
    chk("post_reset/dv", DATA_VALID, 0);
    chk("post_reset/par_err", PAR_ERR, 0);
    chk("post_reset/stp_err", STP_ERR, 0);
    add_frame(8'h99, 0, 1);
    drive("after_reset_99", 8, -1);

    // Random frames, including illegal prescale values that fall back to 8.
    for (int n = 0; n < 12; n++) begin
      begin_batch(plist[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      add_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      drive("random", 8, -1);
    end

    chk("pulse_width", long_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the system UART link. Deserialises frames sent by the TX path: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Runs on an oversampling clock at PRESCALE × baud. Delivers the parallel byte with a one-cycle valid pulse to the register-file/FIFO side.
- Flags parity and stop (framing) errors.

Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_W, 6, width of PRESCALE input and edge counter

Ports:
- CLK  in  1  oversampling clock (PRESCALE × baud)
- RST  in  1  reset, synchronous, active-high
- RX_IN  in  1  serial line, idle high, asynchronous to CLK
- PRESCALE  in  PRESCALE_W  oversampling ratio; legal 8, 16, 32
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  last good received word
- DATA_VALID  out  1  one-cycle pulse, P_DATA updated
- PAR_ERR  out  1  one-cycle pulse, parity mismatch
- STP_ERR  out  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset (RST high at a CLK edge) clears all outputs, counters and the synchroniser to defaults: P_DATA=0, DATA_VALID=PAR_ERR=STP_ERR=0, FSM=IDLE, synchroniser flops=1. Reset mid-frame abandons the frame with no flags.
- RX_IN passes through a 2-flop synchroniser. All logic below uses the synchronised value rx_s, which lags RX_IN by 2 cycles.
- Configuration latch:
  - PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE→START transition and held for the whole frame.
  - A latched PRESCALE other than 8, 16 or 32 is replaced by 8.
- Counters:
  - edge_cnt counts 0..P-1 within each bit (P = latched prescale) and wraps to 0.
  - bit_cnt increments on each wrap.
- Sampler:
  - Captures rx_s at edge_cnt = P/2-1, P/2 and P/2+1.
  - sampled_bit is the 2-of-3 majority, valid from edge_cnt = P/2+2 until the end of the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: rx_s=0 → START, edge_cnt=0.
  - START: at edge_cnt=P-1, sampled_bit=1 means glitch: return to IDLE with no outputs. Otherwise → DATA, bit_cnt=0.
  - DATA: at each edge_cnt=P-1, sampled_bit shifts into the shift register LSB first. After the DATA_WIDTH-th bit, go to PARITY if PAR_EN else STOP.
  - PARITY: at edge_cnt=P-1, compare sampled_bit with the expected parity, then → STOP. Expected parity is ^data for even and ~^data for odd. A mismatch sets the internal par_bad flag.
  - STOP: at edge_cnt=P-1, sampled_bit=0 sets stp_bad, then → DONE.
  - DONE lasts exactly one cycle:
    - If par_bad=0 and stp_bad=0: DATA_VALID=1 and P_DATA is loaded.
    - Otherwise PAR_ERR=par_bad and STP_ERR=stp_bad; both may be high together. P_DATA is unchanged.
    - Exit: → START if rx_s=0 (back-to-back frame, edge_cnt=0), else → IDLE.
- Latency: DATA_VALID rises 1 cycle after the last stop-bit edge cycle, plus the 2-cycle synchroniser lag relative to RX_IN.
- Break or all-zero line: a low stop bit gives STP_ERR. The FSM then re-enters START only if the line is still low in DONE; if it is still low after that, START is taken at the next start check.
- Output pulses never last more than one cycle. At most one DONE occurs per frame.

Decomposition:
- Shared package uart_pkg holds:
  - the RX state encoding localparams;
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1, shared with the TX path;
  - the legal-prescale constants 8, 16 and 32.
- One sub-module, uart_rx_sampler: the three-point capture plus majority vote, with inputs CLK, RST, rx_s, edge_cnt and half_p, and output sampled_bit.
- FSM, counters, shift register and parity check stay in uart_rx.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 → DATA_VALID pulse 1 cycle, P_DATA=0xA5, PAR_ERR=STP_ERR=0; pulse at 80 cycles + 2 after the start-bit falling edge.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 → P_DATA=0x3C. Same frame with parity bit 1 → PAR_ERR pulse, DATA_VALID=0, P_DATA keeps 0x3C.
- P=32, 0x81 with stop bit 0 → STP_ERR pulse, no DATA_VALID. The next correct frame 0x7E is received cleanly.
- Start glitch: RX_IN low for 3 cycles at P=16 → back to IDLE, no output pulses. A following frame 0x55 is received correctly.
- Majority vote: P=16, one of the three samples in data bit 2 inverted → P_DATA still correct (0xF0 expected and received).
- Back-to-back 0x11, 0x22 with no idle gap at P=8, plus RST asserted mid-frame on a third frame → two DATA_VALID pulses with the correct data. After reset, all outputs are 0 and the next frame 0x99 is received.
